// File: rtl/k_dsp_pkg.sv
// Shared types and defaults for the K_DSP frame scan path.
// Scan FSM state encoding plus default buffer geometry and latency.
package k_dsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam int K_DEPTH   = 240;
    localparam int K_WIDTH   = 8;
    localparam int K_DEPTH_W = 8;
    localparam int K_WIDTH_W = 3;
    localparam int K_RD_LAT  = 2;

    // Bits needed to count 0..lat-1 (at least one bit).
    function automatic int flush_cnt_w(input int lat);
        return (lat < 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/k_valid_delay.sv
// Fixed-latency shift register aligning read strobes with buffer data.
// Sync clear drops every in-flight entry, including the one entering.
module k_valid_delay #(
    parameter int LAT = 2,
    parameter int DW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [LAT-1:0][DW-1:0] sr;

    // Shift every cycle; stalls never freeze in-flight strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[LAT-1];

endmodule

// File: rtl/k_scan_controller.sv
// Frame scan sequencer for the K_DSP sample buffer.
// Define K_SCAN_LAST_EN to add the row_last / frame_last outputs.
module k_scan_controller
    import k_dsp_pkg::*;
#(
    parameter int DEPTH   = K_DEPTH,
    parameter int WIDTH   = K_WIDTH,
    parameter int DEPTH_W = K_DEPTH_W,
    parameter int WIDTH_W = K_WIDTH_W,
    parameter int RD_LAT  = K_RD_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [WIDTH_W-1:0] address_width,
    output logic [DEPTH_W-1:0] address_depth,
    output logic               data_valid
`ifdef K_SCAN_LAST_EN
    ,
    output logic               row_last,
    output logic               frame_last
`endif
);

    localparam int CW = flush_cnt_w(RD_LAT);
`ifdef K_SCAN_LAST_EN
    localparam int DW = 3;
`else
    localparam int DW = 1;
`endif

    scan_state_t   state;
    logic [CW-1:0] fcnt;
    logic          depth_end;
    logic          row_end;
    logic          frame_end;
    logic          in_frame;
    logic          clr;
    logic [DW-1:0] dly_in;
    logic [DW-1:0] dly_out;

    assign depth_end = (address_depth == DEPTH_W'(DEPTH - 1));
    assign row_end   = (address_width == WIDTH_W'(WIDTH - 1));
    assign frame_end = depth_end & row_end;
    assign in_frame  = (state == RUN) | (state == FLUSH);

    // A cancelled cycle issues no read; its strobe would be flushed anyway.
    assign rd_en = (state == RUN) & ~stall & ~abort;
    assign clr   = abort & in_frame;

`ifdef K_SCAN_LAST_EN
    assign dly_in     = {rd_en & frame_end, rd_en & depth_end, rd_en};
    assign data_valid = dly_out[0];
    assign row_last   = dly_out[1];
    assign frame_last = dly_out[2];
`else
    assign dly_in     = rd_en;
    assign data_valid = dly_out[0];
`endif

    k_valid_delay #(
        .LAT (RD_LAT),
        .DW  (DW)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .din  (dly_in),
        .dout (dly_out)
    );

    // Scan FSM, index counters, drain counter and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            fcnt          <= '0;
            address_width <= '0;
            address_depth <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        address_width <= '0;
                        address_depth <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        address_width <= '0;
                        address_depth <= '0;
                    end else if (!stall) begin
                        if (frame_end) begin
                            state         <= FLUSH;
                            fcnt          <= '0;
                            address_width <= '0;
                            address_depth <= '0;
                        end else if (depth_end) begin
                            address_depth <= '0;
                            address_width <= address_width + 1'b1;
                        end else begin
                            address_depth <= address_depth + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fcnt == CW'(RD_LAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
